// File: rtl/cam_dvp_tx.sv
// cam_dvp_tx -- DVP-style camera transmitter generating test-pattern frames.
//
// Ports:
//   clk          single clock for all logic
//   reset_n      asynchronous active-low reset
//   enable       request continuous frame generation
//   pattern      test-pattern select (latched at each frame start)
//   solid_color  RGB565 value for pattern 0
//   cam_pclk     pixel clock (clk/2); a "tick" is the clk edge where it falls
//   cam_vsync    frame sync, active high
//   cam_href     line valid, active high
//   cam_data     byte lane (RGB565 high byte first, then low byte)
//   busy         high whenever the FSM is not in IDLE
//   frame_count  completed-frame counter
//
// Optional feature: define CAM_DVP_TX_FRAMECNT_EN to build the frame counter;
// otherwise frame_count is tied to zero.
module cam_dvp_tx #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 144,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 17,
  parameter int V_FRONT  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  pattern,
  input  logic [15:0] solid_color,
  output logic        cam_pclk,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam logic [15:0] LINE_LAST = 16'(2 * H_ACTIVE + H_BLANK - 1);
  localparam logic [15:0] HREF_END  = 16'(2 * H_ACTIVE);
  localparam logic [15:0] VS_LAST   = 16'(V_SYNC - 1);
  localparam logic [15:0] VB_LAST   = 16'(V_BACK - 1);
  localparam logic [15:0] VA_LAST   = 16'(V_ACTIVE - 1);
  localparam logic [15:0] VF_LAST   = 16'(V_FRONT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_t;

  state_t      r_state, w_nstate;
  logic        r_pclk;
  logic [15:0] r_h, r_v;        // tick within line, line within phase
  logic [15:0] w_nh, w_nv;
  logic [15:0] w_vlast;
  logic [15:0] r_pix;           // pattern-3 pixel index
  logic [15:0] w_pix;
  logic [1:0]  r_pat;
  logic [7:0]  r_lo;            // low byte held from the high-byte tick
  logic        r_vsync, r_href;
  logic [7:0]  r_data;
  logic        w_tick, w_start, w_href;

  // pclk was high, so this edge drives it low: a tick.
  assign w_tick = r_pclk;

  always_comb begin
    case (r_state)
      S_VSYNC:  w_vlast = VS_LAST;
      S_VBACK:  w_vlast = VB_LAST;
      S_ACTIVE: w_vlast = VA_LAST;
      default:  w_vlast = VF_LAST;
    endcase
  end

  // Next position (state, tick-in-line, line-in-phase) after this tick.
  always_comb begin
    w_nstate = r_state;
    w_nh     = r_h;
    w_nv     = r_v;
    w_start  = 1'b0;
    if (r_state == S_IDLE) begin
      if (enable) begin
        w_nstate = S_VSYNC;
        w_nh     = '0;
        w_nv     = '0;
        w_start  = 1'b1;
      end
    end else if (r_h != LINE_LAST) begin
      w_nh = r_h + 16'd1;
    end else begin
      w_nh = '0;
      if (r_v != w_vlast) begin
        w_nv = r_v + 16'd1;
      end else begin
        w_nv = '0;
        case (r_state)
          S_VSYNC:  w_nstate = S_VBACK;
          S_VBACK:  w_nstate = S_ACTIVE;
          S_ACTIVE: w_nstate = S_VFRONT;
          default: begin
            if (enable) begin
              w_nstate = S_VSYNC;
              w_start  = 1'b1;
            end else begin
              w_nstate = S_IDLE;
            end
          end
        endcase
      end
    end
  end

  // Pixel at column x = w_nh/2, line y = w_nv (only used while href).
  always_comb begin
    case (r_pat)
      2'd0:    w_pix = solid_color;
      2'd1:    w_pix = {w_nh[5:1], w_nh[6:1], w_nh[5:1]};
      2'd2:    w_pix = (w_nh[5] ^ w_nv[4]) ? 16'hFFFF : 16'h0000;
      default: w_pix = r_pix;
    endcase
  end

  assign w_href = (w_nstate == S_ACTIVE) && (w_nh < HREF_END);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_pclk <= 1'b0;
    else          r_pclk <= ~r_pclk;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_state <= S_IDLE;
    else if (w_tick) r_state <= w_nstate;
  end

  // Outputs are registered from the next position so they only move on ticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h     <= '0;
      r_v     <= '0;
      r_pix   <= '0;
      r_pat   <= '0;
      r_lo    <= '0;
      r_vsync <= 1'b0;
      r_href  <= 1'b0;
      r_data  <= '0;
    end else if (w_tick) begin
      r_h     <= w_nh;
      r_v     <= w_nv;
      r_vsync <= (w_nstate == S_VSYNC);
      r_href  <= w_href;
      if (w_start) begin
        r_pat <= pattern;
        r_pix <= '0;
      end
      if (!w_href) begin
        r_data <= '0;
      end else if (!w_nh[0]) begin
        r_data <= w_pix[15:8];
        r_lo   <= w_pix[7:0];
        r_pix  <= r_pix + 16'd1;
      end else begin
        r_data <= r_lo;
      end
    end
  end

`ifdef CAM_DVP_TX_FRAMECNT_EN
  logic [15:0] r_fcnt;
  logic        w_fdone;

  assign w_fdone = (r_state == S_VFRONT) && (r_h == LINE_LAST) && (r_v == VF_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               r_fcnt <= '0;
    else if (w_tick && w_fdone) r_fcnt <= r_fcnt + 16'd1;
  end

  assign frame_count = r_fcnt;
`else
  assign frame_count = '0;
`endif

  assign cam_pclk  = r_pclk;
  assign cam_vsync = r_vsync;
  assign cam_href  = r_href;
  assign cam_data  = r_data;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_cam_dvp_tx.sv
// tb_cam_dvp_tx -- self-checking bench for cam_dvp_tx with a small frame
// geometry (L = 10 ticks, 50 ticks per frame).
module tb_cam_dvp_tx;

  localparam int HA = 4;
  localparam int HB = 2;
  localparam int VA = 2;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int VF = 1;
  localparam int L  = 2 * HA + HB;
  localparam int FR = L * (VS + VB + VA + VF);

`ifdef CAM_DVP_TX_FRAMECNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  pattern = 2'd0;
  logic [15:0] solid_color = 16'h0000;
  logic        cam_pclk, cam_vsync, cam_href, busy;
  logic [7:0]  cam_data;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_print  = 0;
  logic [15:0] exp_fc = 16'h0;

  cam_dvp_tx #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .V_SYNC(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pattern(pattern),
    .solid_color(solid_color), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .busy(busy),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       vs;
    logic       hr;
    logic [7:0] d;
  } exp_t;

  typedef struct {
    int         k;
    logic       vs;
    logic       hr;
    logic [7:0] d;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // Expected outputs for frame tick k, derived from line/column arithmetic.
  function automatic exp_t model(input int k, input int pat, input logic [15:0] solid);
    exp_t e;
    int line, col, x, y;
    logic [15:0] pix;
    line = k / L;
    col  = k % L;
    e.vs = (line < VS);
    e.hr = (line >= VS + VB) && (line < VS + VB + VA) && (col < 2 * HA);
    e.d  = 8'h00;
    if (e.hr) begin
      x = col / 2;
      y = line - VS - VB;
      case (pat)
        0:       pix = solid;
        1:       pix = 16'(((x & 31) << 11) | ((x & 63) << 5) | (x & 31));
        2:       pix = ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 16'hFFFF : 16'h0000;
        default: pix = 16'((y * HA + x) & 16'hFFFF);
      endcase
      e.d = (col % 2 == 0) ? pix[15:8] : pix[7:0];
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] fc_exp();
    return FC_EN ? exp_fc : 16'h0000;
  endfunction

  // Assert reset mid-clock, check outputs clear at once, release and align.
  task automatic apply_reset();
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("reset_async", {cam_pclk, cam_vsync, cam_href, cam_data, busy, frame_count},
        32'h0);
    enable = 1'b0;
    exp_fc = 16'h0;
    step();
    step();
    chk("reset_held", {cam_pclk, cam_vsync, cam_href, cam_data, busy, frame_count},
        32'h0);
    reset_n = 1'b1;
    step();
    chk("first_edge_pclk", cam_pclk, 1);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_tick", {cam_pclk, cam_vsync, cam_href, cam_data, busy}, 32'h0);
      chk("idle_frame_count", frame_count, fc_exp());
      step();
      chk("idle_pclk_rise", cam_pclk, 1);
    end
  endtask

  task automatic run_frame(input int pat, input logic [15:0] solid, input int drop_at,
                           input int chg_at, input logic [1:0] new_pat);
    exp_t e;
    solid_color = solid;
    for (int k = 0; k < FR; k++) begin
      step();
      e = model(k, pat, solid);
      chk("tick_pclk", cam_pclk, 0);
      chk("vsync", cam_vsync, e.vs);
      chk("href", cam_href, e.hr);
      chk("data", cam_data, e.d);
      chk("busy", busy, 1);
      if (k == 0) chk("frame_count", frame_count, fc_exp());
      step();
      chk("pclk_rise", cam_pclk, 1);
      chk("hold_over_rise", {cam_vsync, cam_href, cam_data}, {e.vs, e.hr, e.d});
      if (k == drop_at) enable = 1'b0;
      if (k == chg_at) pattern = new_pat;
    end
    exp_fc = exp_fc + 16'd1;
  endtask

  vec_t tbl[20];
  exp_t e;
  int   ptr;
  bit   hit;
  int   cur_pat, chg, np, gap;
  bit   last;
  logic [15:0] sc;

  initial begin
    tbl[0]  = '{0,  1'b1, 1'b0, 8'h00};
    tbl[1]  = '{9,  1'b1, 1'b0, 8'h00};
    tbl[2]  = '{10, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{19, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{20, 1'b0, 1'b1, 8'h00};
    tbl[5]  = '{21, 1'b0, 1'b1, 8'h00};
    tbl[6]  = '{22, 1'b0, 1'b1, 8'h00};
    tbl[7]  = '{23, 1'b0, 1'b1, 8'h01};
    tbl[8]  = '{25, 1'b0, 1'b1, 8'h02};
    tbl[9]  = '{27, 1'b0, 1'b1, 8'h03};
    tbl[10] = '{28, 1'b0, 1'b0, 8'h00};
    tbl[11] = '{29, 1'b0, 1'b0, 8'h00};
    tbl[12] = '{30, 1'b0, 1'b1, 8'h00};
    tbl[13] = '{31, 1'b0, 1'b1, 8'h04};
    tbl[14] = '{33, 1'b0, 1'b1, 8'h05};
    tbl[15] = '{35, 1'b0, 1'b1, 8'h06};
    tbl[16] = '{37, 1'b0, 1'b1, 8'h07};
    tbl[17] = '{38, 1'b0, 1'b0, 8'h00};
    tbl[18] = '{40, 1'b0, 1'b0, 8'h00};
    tbl[19] = '{49, 1'b0, 1'b0, 8'h00};

    // Reset state and no frame without enable.
    apply_reset();
    idle_ticks(3);

    // Pattern 3 index frame against fixed vectors.
    pattern = 2'd3;
    enable  = 1'b1;
    ptr = 0;
    for (int k = 0; k < FR; k++) begin
      step();
      hit = 1'b0;
      if (ptr < 20 && tbl[ptr].k == k) begin
        hit = 1'b1;
        chk("tbl_tick", {cam_vsync, cam_href, cam_data}, {tbl[ptr].vs, tbl[ptr].hr, tbl[ptr].d});
      end
      step();
      if (hit) begin
        chk("tbl_hold", {cam_vsync, cam_href, cam_data}, {tbl[ptr].vs, tbl[ptr].hr, tbl[ptr].d});
        ptr++;
      end
      if (k == FR - 1) enable = 1'b0;
    end
    exp_fc = exp_fc + 16'd1;
    idle_ticks(2);

    // Solid colour frame.
    pattern = 2'd0;
    enable  = 1'b1;
    run_frame(0, 16'hF81F, FR - 1, -1, 2'd0);
    idle_ticks(2);

    // Enable dropped mid-frame: frame completes, then IDLE.
    apply_reset();
    pattern = 2'd3;
    enable  = 1'b1;
    run_frame(3, 16'h0000, 15, -1, 2'd0);
    idle_ticks(4);

    // Three back-to-back frames, pattern changed during frame 2.
    apply_reset();
    pattern = 2'd3;
    enable  = 1'b1;
    run_frame(3, 16'h0000, -1, -1, 2'd0);
    run_frame(3, 16'h0000, -1, 25, 2'd1);
    run_frame(1, 16'h0000, FR - 1, -1, 2'd0);
    idle_ticks(2);

    // Reset pulsed during ACTIVE.
    apply_reset();
    pattern = 2'd0;
    solid_color = 16'h1234;
    enable = 1'b1;
    for (int k = 0; k < 25; k++) begin
      step();
      e = model(k, 0, 16'h1234);
      chk("pre_reset_data", {cam_vsync, cam_href, cam_data}, {e.vs, e.hr, e.d});
      step();
    end
    chk("pre_reset_active", cam_href, 1);
    apply_reset();
    idle_ticks(6);
    pattern = 2'd2;
    enable  = 1'b1;
    run_frame(2, 16'h0000, FR - 1, -1, 2'd0);
    idle_ticks(1);

    // Randomized frames against the reference model.
    apply_reset();
    cur_pat = $urandom_range(0, 3);
    pattern = 2'(cur_pat);
    enable  = 1'b1;
    for (int f = 0; f < 8; f++) begin
      sc   = 16'($urandom);
      chg  = $urandom_range(0, 70);
      np   = $urandom_range(0, 3);
      last = (f == 7) || ($urandom_range(0, 2) == 0);
      run_frame(cur_pat, sc, last ? FR - 1 : -1, chg, 2'(np));
      if (chg < FR) cur_pat = np;
      if (last) begin
        gap = $urandom_range(1, 4);
        idle_ticks(gap);
        enable = 1'b1;
      end
    end
    enable = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_dvp_tx.md
CAM_DVP_TX -- requirements
Module: cam_dvp_tx

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 SHALL have parameter H_BLANK, default 144: href-low ticks after each active line.
REQ-004 SHALL have parameters V_SYNC, V_BACK and V_FRONT, defaults 3, 17 and 10: line counts of the sync, back-porch and front-porch periods.
REQ-005 SHALL have port clk, input, 1 bit: single clock for all logic. One clock; reset is asynchronous and active-low.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1 bit: request continuous frame generation.
REQ-008 SHALL have port pattern, input, 2 bits: test-pattern select.
REQ-009 SHALL have port solid_color, input, 16 bits: RGB565 value used by pattern 0.
REQ-010 SHALL have port cam_pclk, output, 1 bit: pixel clock.
REQ-011 SHALL have port cam_vsync, output, 1 bit: frame sync, active high.
REQ-012 SHALL have port cam_href, output, 1 bit: line valid, active high.
REQ-013 SHALL have port cam_data, output, 8 bits: byte lane.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-015 SHALL have port frame_count, output, 16 bits: count of completed frames.

Function
REQ-016 SHALL toggle cam_pclk on every clk edge after reset; a "tick" is the clk edge on which cam_pclk goes 0.
REQ-017 SHALL change cam_vsync, cam_href and cam_data only on ticks, so all three are stable across the cam_pclk rising edge.
REQ-018 SHALL define line length L = 2*H_ACTIVE + H_BLANK ticks.
REQ-019 SHALL implement the FSM states IDLE, VSYNC, VBACK, ACTIVE and VFRONT, with transitions evaluated on ticks only.
REQ-020 SHALL stay in IDLE with vsync/href/data at 0; on a tick where enable=1 it SHALL latch pattern and go to VSYNC.
REQ-021 SHALL drive cam_vsync=1 for V_SYNC*L ticks in VSYNC, then go to VBACK.
REQ-022 SHALL hold vsync and href at 0 for V_BACK*L ticks in VBACK, then go to ACTIVE.
REQ-023 SHALL, in ACTIVE, repeat V_ACTIVE times: href=1 for 2*H_ACTIVE ticks, then href=0 for H_BLANK ticks.
REQ-024 SHALL, while href=1, send each pixel as two bytes on consecutive ticks: RGB565[15:8] first, then [7:0].
REQ-025 SHALL drive cam_data=0 while href=0.
REQ-026 SHALL, after VFRONT (V_FRONT*L ticks, all low), go to VSYNC and relatch pattern if enable=1, else go to IDLE.
REQ-027 SHALL NOT abort a frame when enable is deasserted mid-frame; the frame completes through VFRONT.
REQ-028 SHALL generate pixels per pattern as follows, where x is the pixel column and y the line, both counted from 0.
- Pattern 0: solid_color, sampled at each pixel.
- Pattern 1: horizontal ramp {x[4:0], x[5:0], x[4:0]}.
- Pattern 2: checker, 16'hFFFF when x[4]^y[4], else 16'h0000.
- Pattern 3: a 16-bit index that starts at 0 each frame, increments per pixel and wraps at 16'hFFFF.
REQ-029 SHALL ignore changes to pattern mid-frame.
REQ-030 SHALL increment frame_count, wrapping at 16'hFFFF, on the tick that leaves VFRONT.

Reset
REQ-031 SHALL, while reset_n=0, immediately force cam_pclk, cam_vsync, cam_href, cam_data, busy and frame_count to 0 and the FSM to IDLE, including mid-frame.
REQ-032 SHALL, after reset_n deasserts, produce its first tick on the second clk edge, and SHALL start no frame before enable is sampled at 1.

Configuration
REQ-033 SHALL, when macro CAM_DVP_TX_FRAMECNT_EN is defined, implement the frame_count counter as in REQ-030.
REQ-034 SHALL, when CAM_DVP_TX_FRAMECNT_EN is undefined, tie frame_count to 16'h0000 with no counter register, leaving all other behaviour identical.

Verification
All scenarios use H_ACTIVE=4, H_BLANK=2, V_ACTIVE=2, V_SYNC=1, V_BACK=1, V_FRONT=1, so L=10 ticks and one frame is 50 ticks (100 clk).
REQ-035 SHALL cover: enable=1, pattern=3 -> vsync high for 10 ticks, 10 ticks low, then bytes 00 00 00 01 00 02 00 03 with href high for 8 ticks and low for 2; line 1 carries 00 04 through 00 07.
REQ-036 SHALL cover: pattern=0, solid_color=16'hF81F -> every active tick pair is F8,1F; cam_data=0 whenever href=0.
REQ-037 SHALL cover: enable dropped at tick 15 of frame 1 -> frame completes, busy falls after tick 50, frame_count=1, and the FSM returns to IDLE.
REQ-038 SHALL cover: enable held for 3 frames, pattern changed mid-frame 2 -> back-to-back frames with no idle gap, the new pattern appears only from frame 3, and frame_count=3.
REQ-039 SHALL cover: reset_n pulsed low during ACTIVE -> all outputs 0 within the same clk, and after release no vsync until enable is sampled.
REQ-040 SHALL cover: each active data byte -> stable from the falling edge through the next rising edge of cam_pclk.
